detect_window_monitor: RTL and testbench
========================================

// Module: detect_window_monitor
// PURPOSE
//   Downstream consumer of the Mealy overlapping sequence detector's 'detected' output.
//   Counts detection pulses over fixed windows of WINDOW clock cycles.
//   Reports each window's count with a one-cycle valid strobe and raises a threshold alarm.
//   Also keeps a saturating running total of all detections.
// PARAMETERS
//   WINDOW  16  sampled cycles per window; legal range >= 2
//   CNT_W   8   width of count/total; counters saturate at 2**CNT_W-1
//   THRESH  3   alarm set when window count >= THRESH; legal range 0..2**CNT_W-1
// PORTS
//   clk          in   1      single clock; all sampling on posedge
//   rst          in   1      asynchronous, active-high reset
//   en           in   1      1 = monitor windows; 0 = idle
//   clear        in   1      synchronous clear, one cycle, priority over en/detected
//   detected     in   1      detector output; may be combinational; sampled at posedge only
//   count        out  CNT_W  detection count of last completed window (held)
//   count_valid  out  1      one-cycle strobe: count updated this cycle
//   alarm        out  1      last completed window count >= THRESH
//   total        out  CNT_W  saturating total of detections sampled in RUN
// BEHAVIOUR
//   Reset (async, no clock needed):
//     state=IDLE, win_cnt=0, acc=0, count=0, count_valid=0, alarm=0, total=0.
//   FSM states: IDLE, RUN (registered state, 1 bit).
//   IDLE:
//     - detected ignored; count/alarm/total hold; count_valid=0.
//     - en=1 at posedge -> RUN with win_cnt=0, acc=0.
//     - First sampled window cycle is the posedge after entry.
//   RUN, each posedge with en=1:
//     - if detected: acc += 1 (saturating) and total += 1 (saturating).
//     - win_cnt += 1.
//   Window end (RUN, en=1, win_cnt==WINDOW-1):
//     - fin = sat(acc + detected); a detection on the last cycle counts in this window.
//     - count <= fin; count_valid <= 1 for exactly one cycle; alarm <= (fin >= THRESH).
//     - acc <= 0, win_cnt <= 0; next window starts immediately, no gap cycle.
//   en=0 sampled in RUN:
//     - -> IDLE; partial window discarded; acc and win_cnt cleared.
//     - No count_valid; count/alarm unchanged.
//     - Detections already added to total remain.
//     - detected in that cycle is not counted.
//   Consecutive high cycles on detected are separate detections (overlap back-to-back hits).
//   Saturation: acc and total stick at 2**CNT_W-1 and never wrap.
//   clear=1 at posedge (any state):
//     - state=IDLE; acc, win_cnt, count, alarm, total all 0; count_valid=0.
//     - detected in that cycle is not counted.
//   rst mid-window: immediate return to reset values; partial window lost.
//   Latency: count_valid is high in the cycle after the posedge sampling the last window cycle.
// CONFIGURATION
//   STICKY_ALARM_EN defined:
//     - alarm is set at any window end with fin >= THRESH.
//     - stays 1 until clear or rst; later windows below THRESH do not drop it.
//   STICKY_ALARM_EN undefined:
//     - alarm reloads at every window end from that window's fin and holds between ends.
// TESTING (WINDOW=16, THRESH=3, CNT_W=8 unless stated)
//   1 rst=1 mid-window with acc=2, total=5:
//       outputs 0 before next clk edge; IDLE after release.
//   2 en=1; detected high on window cycles 2,3,9:
//       16 cycles later count=3, count_valid high 1 cycle, alarm=1, total=3.
//   3 next window with detections on cycles 0 and 15:
//       count=2, alarm=0 (no macro), total=5.
//   4 CNT_W=3, detected held high 16 cycles:
//       count=7, total=7; total stays 7 next window.
//   5 en dropped after 8 window cycles with 2 detections:
//       no count_valid, count unchanged, total += 2.
//       After re-enable, window restarts at cycle 0.
//   6 clear pulsed mid-window with alarm=1:
//       count=0, alarm=0, total=0, IDLE.
//   7 STICKY_ALARM_EN, window with 3 detections then window with 0:
//       alarm stays 1 (falls to 0 without macro); clear drops it.

Source files
------------

// File: rtl/detect_window_monitor.sv
// detect_window_monitor
//   Downstream consumer of a sequence detector's 'detected' output. Counts
//   detection pulses over back-to-back windows of WINDOW sampled cycles,
//   reports each completed window's count with a one-cycle strobe, raises an
//   alarm when that count reaches THRESH, and keeps a saturating running
//   total of every detection sampled while monitoring.
//
// Parameters
//   WINDOW  sampled cycles per window (>= 2)
//   CNT_W   width of count/total; counters saturate at 2**CNT_W-1
//   THRESH  alarm threshold (0 .. 2**CNT_W-1)
//
// Ports
//   clk          in   single clock, posedge sampling
//   rst          in   asynchronous active-high reset
//   en           in   1 = monitor windows, 0 = idle
//   clear        in   synchronous clear, priority over en/detected
//   detected     in   detector output, sampled on posedge only
//   count        out  detection count of last completed window (held)
//   count_valid  out  one-cycle strobe when count is updated
//   alarm        out  last completed window count >= THRESH
//   total        out  saturating total of detections sampled while running
//
// Configuration
//   STICKY_ALARM_EN  when defined, alarm latches at the first window end that
//                    reaches THRESH and holds until clear or rst; otherwise it
//                    reloads from each window's count at every window end.

module detect_window_monitor #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8,
  parameter int THRESH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             detected,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             alarm,
  output logic [CNT_W-1:0] total
);

  localparam int               WIN_W   = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_END = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] acc;

  logic [CNT_W-1:0] fin;
  logic [CNT_W-1:0] total_nxt;
  logic             hit;
  logic             alarm_nxt;

  // fin folds the current cycle's detection into the accumulator so a hit on
  // the last window cycle lands in that window's reported count.
  always_comb begin
    fin       = acc;
    total_nxt = total;
    if (detected && (acc != CNT_MAX)) begin
      fin = acc + CNT_W'(1);
    end
    if (detected && (total != CNT_MAX)) begin
      total_nxt = total + CNT_W'(1);
    end
    hit = (fin >= THR);
`ifdef STICKY_ALARM_EN
    alarm_nxt = alarm | hit;
`else
    alarm_nxt = hit;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      win_cnt     <= '0;
      acc         <= '0;
      count       <= '0;
      count_valid <= 1'b0;
      alarm       <= 1'b0;
      total       <= '0;
    end else if (clear) begin
      state       <= IDLE;
      win_cnt     <= '0;
      acc         <= '0;
      count       <= '0;
      count_valid <= 1'b0;
      alarm       <= 1'b0;
      total       <= '0;
    end else begin
      count_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state   <= RUN;
            win_cnt <= '0;
            acc     <= '0;
          end
        end
        RUN: begin
          if (!en) begin
            // Partial window is dropped; detections already in total stay.
            state   <= IDLE;
            win_cnt <= '0;
            acc     <= '0;
          end else begin
            total <= total_nxt;
            if (win_cnt == WIN_END) begin
              count       <= fin;
              count_valid <= 1'b1;
              alarm       <= alarm_nxt;
              acc         <= '0;
              win_cnt     <= '0;
            end else begin
              acc     <= fin;
              win_cnt <= win_cnt + WIN_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_detect_window_monitor.sv
module tb_detect_window_monitor;

  localparam int WINDOW = 16;
  localparam int THRESH = 3;
  localparam int MAXV   = 255;

  logic       clk = 1'b0;
  logic       rst, en, clear, detected;
  logic [7:0] count, total;
  logic       count_valid, alarm;

  // Narrow instance for saturation behaviour
  logic       s_en, s_det, s_clr;
  logic [2:0] s_count, s_total;
  logic       s_valid, s_alarm;

  always #5 clk = ~clk;

  detect_window_monitor #(.WINDOW(WINDOW), .CNT_W(8), .THRESH(THRESH)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .detected(detected),
    .count(count), .count_valid(count_valid), .alarm(alarm), .total(total)
  );

  detect_window_monitor #(.WINDOW(WINDOW), .CNT_W(3), .THRESH(THRESH)) u_sat (
    .clk(clk), .rst(rst), .en(s_en), .clear(s_clr), .detected(s_det),
    .count(s_count), .count_valid(s_valid), .alarm(s_alarm), .total(s_total)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  typedef struct {
    int unsigned cnt;
    int unsigned alm;
    int unsigned tot;
  } exp_t;
  exp_t sb[$];

  // Reference model of the monitor
  bit          m_run;
  int unsigned m_win, m_acc, m_count, m_alarm, m_total, m_valid;

  function automatic int unsigned sat_inc(input int unsigned v, input bit d);
    return (d && v < MAXV) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_run = 0; m_win = 0; m_acc = 0; m_count = 0; m_alarm = 0; m_total = 0; m_valid = 0;
  endtask

  task automatic model_step();
    int unsigned f;
    exp_t e;
    m_valid = 0;
    if (clear) begin
      model_reset();
    end else if (!m_run) begin
      if (en) begin m_run = 1; m_win = 0; m_acc = 0; end
    end else if (!en) begin
      m_run = 0; m_win = 0; m_acc = 0;
    end else begin
      m_total = sat_inc(m_total, detected);
      f = sat_inc(m_acc, detected);
      if (m_win == WINDOW - 1) begin
        m_count = f;
`ifdef STICKY_ALARM_EN
        m_alarm = (m_alarm != 0 || f >= THRESH) ? 1 : 0;
`else
        m_alarm = (f >= THRESH) ? 1 : 0;
`endif
        m_valid = 1;
        m_acc = 0; m_win = 0;
        e.cnt = m_count; e.alm = m_alarm; e.tot = m_total;
        sb.push_back(e);
      end else begin
        m_acc = f; m_win++;
      end
    end
  endtask

  // One clock: drive at negedge, model at posedge, sample at next negedge
  task automatic step(input bit e, input bit d, input bit c);
    exp_t x;
    en = e; detected = d; clear = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("count_valid", count_valid, m_valid);
    if (count_valid) begin
      chk("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("win_count", count, x.cnt);
        chk("win_alarm", alarm, x.alm);
        chk("win_total", total, x.tot);
      end
    end
    chk("count", count, m_count);
    chk("alarm", alarm, m_alarm);
    chk("total", total, m_total);
  endtask

  task automatic run_window(input logic [15:0] pat);
    for (int i = 0; i < WINDOW; i++) step(1'b1, pat[i], 1'b0);
  endtask

  initial begin
    int unsigned nv;
    rst = 1'b1; en = 1'b0; detected = 1'b0; clear = 1'b0;
    s_en = 1'b0; s_det = 1'b0; s_clr = 1'b0;
    model_reset();
    #1;
    chk("rst_count", count, 0);
    chk("rst_valid", count_valid, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_total", total, 0);
    @(negedge clk);
    rst = 1'b0;

    // Idle ignores detections
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    // Enter RUN, then windows: hits on 2,3,9; then 0,15; then 3 hits; then none
    step(1'b1, 1'b1, 1'b0);
    run_window(16'h020C);
    run_window(16'h8001);
    run_window(16'h0111);
    run_window(16'h0000);

    // Drop en after 8 window cycles with 2 hits, then re-enable
    for (int i = 0; i < 8; i++) step(1'b1, (i == 1 || i == 5), 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    run_window(16'h0010);

    // Alarm window, then clear mid-window with detected high
    run_window(16'hF000);
    for (int i = 0; i < 5; i++) step(1'b1, i[0], 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Build a window with a nonzero count, then async reset mid-window
    step(1'b1, 1'b0, 1'b0);
    run_window(16'h00F0);
    for (int i = 0; i < 5; i++) step(1'b1, (i < 2), 1'b0);
    en = 1'b0; detected = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_valid", count_valid, 0);
    chk("arst_alarm", alarm, 0);
    chk("arst_total", total, 0);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    run_window(16'h0003);
    step(1'b0, 1'b0, 1'b0);

    // Saturation on the 3-bit instance: detected held high for two windows
    s_en = 1'b1;
    @(negedge clk);
    s_det = 1'b1;
    nv = 0;
    for (int i = 0; i < 2 * WINDOW; i++) begin
      @(negedge clk);
      if (s_valid) begin
        nv++;
        chk("sat_count", s_count, 7);
        chk("sat_total_v", s_total, 7);
        chk("sat_alarm", s_alarm, 1);
      end
      if (i == 9) chk("sat_total_mid", s_total, 7);
    end
    chk("sat_valid_n", nv, 2);
    s_en = 1'b0; s_det = 1'b0;

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
